async_sram_target: RTL
======================

# async_sram_target

Responder end of the parallel asynchronous-SRAM protocol: lets an external host (FPGA, MCU or test rig) drive our SRAM-style pins (A, DQ, CS_n, WE_n, OE_n, UB_n, LB_n) as if we were an async SRAM. Pin activity is synchronised into `clk` and converted into single-outstanding word requests on an internal valid/ready bus. It sits between the pad ring (padin/padout/padoe nets, no pads instantiated) and a system bus bridge.

## Interface
Parameters:
- `N_SRAM_A`, 18, word-address width
- `N_SRAM_DQ`, 16, data width; must be 16
- `SYNC_STAGES`, 2, synchroniser depth applied to every pin input; legal range 2–3

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `padin_sram_a`  in  N_SRAM_A  address from host
- `padin_sram_dq`  in  N_SRAM_DQ  write data from host
- `padin_sram_cs_n`, `padin_sram_we_n`, `padin_sram_oe_n`, `padin_sram_ub_n`, `padin_sram_lb_n`  in  1 each  host strobes
- `padout_sram_dq`  out  N_SRAM_DQ  read data to host
- `padoe_sram_dq`  out  N_SRAM_DQ  DQ output enable, all bits identical
- `bus_req`  out  1  request valid
- `bus_ready`  in  1  request accepted/completed this cycle
- `bus_write`  out  1  1 = write, 0 = read
- `bus_addr`  out  N_SRAM_A  word address
- `bus_wdata`  out  N_SRAM_DQ  write data
- `bus_byte_en`  out  2  bit1 = upper byte, bit0 = lower byte
- `bus_rdata`  in  N_SRAM_DQ  read data, valid when `bus_ready && !bus_write`
- `overrun`  out  1  sticky: a write was dropped because the bus was still busy

## Operation
- All pin inputs pass through `SYNC_STAGES` flops (suffix `_s`), plus one extra delayed copy (`_sd`).
- FSM states: IDLE, WR_REQ, RD_WAIT, RD_REQ, RD_DRIVE.
- IDLE: `we_sd=0 && we_s=1 && cs_sd=0` (WE rising edge while selected) → latch `a_sd`, `dq_sd`, byte lanes → WR_REQ. `cs_s=0 && oe_s=0 && we_s=1` → RD_WAIT.
- WR_REQ: `bus_req=1, bus_write=1`; hold all bus outputs until `bus_ready` → IDLE.
- RD_WAIT: `a_s == a_sd` for one cycle → RD_REQ. Deselect (`cs_s=1` or `oe_s=1`) → IDLE.
- RD_REQ: `bus_req=1, bus_write=0`, `bus_byte_en=2'b11`; on `bus_ready` register `bus_rdata` into `padout_sram_dq` → RD_DRIVE.
- RD_DRIVE: `padoe_sram_dq` all ones. Change in `a_s` → RD_WAIT with the old data still driven. Deselect → `padoe` cleared at the next edge → IDLE.
- A WE rising edge seen in any non-IDLE state is dropped and sets `overrun`. The flag clears only on `rst`.
- `bus_req` never deasserts before `bus_ready`. Its outputs are stable while requesting. Only one request is outstanding at a time.
- Reset (any time, including mid-request): state IDLE; `bus_req`, `padoe_sram_dq`, `padout_sram_dq`, `overrun`, `bus_*` outputs all 0; synchronisers cleared to inactive (strobes high, others 0).

## Timing
- Host write contract: A, DQ, UB/LB stable ≥ `SYNC_STAGES`+1 clk before the WE_n rise and ≥1 clk after. WE_n low for ≥2 clk. Successive WE_n rises spaced ≥ `SYNC_STAGES`+3 clk plus bus wait.
- Write latency: `bus_req` rises `SYNC_STAGES`+1 edges after the first edge sampling WE_n high.
- Read access with a zero-wait bus: `padout`/`padoe` valid `SYNC_STAGES`+3 edges after A, CS_n and OE_n settle. Each bus wait cycle adds 1.
- DQ turn-off: `padoe` drops `SYNC_STAGES`+1 edges after OE_n or CS_n rises. The host must not drive DQ before then.
- Write data is taken from the `_sd` stage, so values sampled while WE is still low are used.

## Configuration
- `ASYNC_SRAM_TARGET_BYTE_LANE_EN`:
  - Defined: `bus_byte_en = ~{ub_n, lb_n}` as latched. A write with both lanes off issues no bus request.
  - Undefined: UB_n/LB_n are ignored (ports kept); every write has `bus_byte_en=2'b11`.

## Structure
- Shared package: FSM state encoding and the `SYNC_STAGES` legal-range constants.
- One sub-module, `async_sram_target_sync`: a parameterised-width multi-stage synchroniser with reset value input, instantiated per pin group.

## Test plan
- Write: A=0x12345, DQ=0xBEEF, UB/LB low, WE pulse 4 clk → exactly one `bus_req` with write=1, addr 0x12345, wdata 0xBEEF, byte_en 2'b11, issued `SYNC_STAGES`+1 edges after WE rises; `overrun` stays 0.
- Read with 2 bus wait states, rdata 0xCAFE, addr 0x00010 → DQ drives 0xCAFE `SYNC_STAGES`+5 edges after strobes settle; `padoe` clears `SYNC_STAGES`+1 edges after OE_n rises.
- Read with the address changed 0x10→0x11 while OE is held low → second read request for 0x11; DQ holds old data until new data arrives.
- Back-to-back write while `bus_ready` is held 0 → second write dropped, `overrun`=1 and sticky until `rst`.
- Byte-lane write UB_n=1, LB_n=0 → byte_en 2'b01 with the macro defined, 2'b11 without it.
- `rst` asserted during RD_REQ → `bus_req` and `padoe` low immediately; FSM returns to IDLE; no spurious request after release.

Source files
------------

// File: rtl/async_sram_target_pkg.sv
// Shared definitions for the async-SRAM responder: FSM encoding and the
// legal synchroniser depth range.
package async_sram_target_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_RD_WAIT,
    ST_RD_REQ,
    ST_RD_DRIVE
  } state_e;
endpackage

// File: rtl/async_sram_target_sync.sv
// Multi-stage pin synchroniser with a programmable reset value; also exposes
// one extra delayed copy so the caller can detect edges and settled values.
module async_sram_target_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] qd_o
);
  // index 0 is the newest sample
  logic [STAGES:0][W-1:0] pipe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= {(STAGES+1){rst_val_i}};
    else     pipe_q <= {pipe_q[STAGES-1:0], d_i};
  end

  assign q_o  = pipe_q[STAGES-1];
  assign qd_o = pipe_q[STAGES];
endmodule

// File: rtl/async_sram_target.sv
// Async-SRAM pin responder: turns host strobes into single-outstanding word
// requests. Build option: ASYNC_SRAM_TARGET_BYTE_LANE_EN honours UB_n/LB_n.
module async_sram_target
  import async_sram_target_pkg::*;
#(
  parameter int N_SRAM_A    = 18,
  parameter int N_SRAM_DQ   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRAM_A-1:0]  padin_sram_a,
  input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
  input  logic                 padin_sram_cs_n,
  input  logic                 padin_sram_we_n,
  input  logic                 padin_sram_oe_n,
  input  logic                 padin_sram_ub_n,
  input  logic                 padin_sram_lb_n,
  output logic [N_SRAM_DQ-1:0] padout_sram_dq,
  output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
  output logic                 bus_req,
  input  logic                 bus_ready,
  output logic                 bus_write,
  output logic [N_SRAM_A-1:0]  bus_addr,
  output logic [N_SRAM_DQ-1:0] bus_wdata,
  output logic [1:0]           bus_byte_en,
  input  logic [N_SRAM_DQ-1:0] bus_rdata,
  output logic                 overrun
);
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX || N_SRAM_DQ != 16) begin : g_bad_param
    $error("async_sram_target: illegal parameter set");
  end

  logic [N_SRAM_A-1:0]  a_s, a_sd;
  logic [N_SRAM_DQ-1:0] dq_s, dq_sd;
  logic [4:0]           strb_s, strb_sd;
  logic cs_s, we_s, oe_s, ub_s, lb_s;
  logic cs_sd, we_sd, oe_sd, ub_sd, lb_sd;

  async_sram_target_sync #(.W(N_SRAM_A), .STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .rst(rst), .rst_val_i('0), .d_i(padin_sram_a), .q_o(a_s), .qd_o(a_sd)
  );
  async_sram_target_sync #(.W(N_SRAM_DQ), .STAGES(SYNC_STAGES)) u_sync_dq (
    .clk(clk), .rst(rst), .rst_val_i('0), .d_i(padin_sram_dq), .q_o(dq_s), .qd_o(dq_sd)
  );
  async_sram_target_sync #(.W(5), .STAGES(SYNC_STAGES)) u_sync_strb (
    .clk(clk), .rst(rst), .rst_val_i(5'b11111),
    .d_i({padin_sram_cs_n, padin_sram_we_n, padin_sram_oe_n, padin_sram_ub_n, padin_sram_lb_n}),
    .q_o(strb_s), .qd_o(strb_sd)
  );

  assign {cs_s,  we_s,  oe_s,  ub_s,  lb_s}  = strb_s;
  assign {cs_sd, we_sd, oe_sd, ub_sd, lb_sd} = strb_sd;

  logic unused_sigs;
  assign unused_sigs = ^{dq_s, oe_sd, ub_s, lb_s, ub_sd, lb_sd};

  logic [1:0] wr_be;
`ifdef ASYNC_SRAM_TARGET_BYTE_LANE_EN
  assign wr_be = ~{ub_sd, lb_sd};
`else
  assign wr_be = 2'b11;
`endif

  logic wr_edge, deselect;
  assign wr_edge  = !we_sd && we_s && !cs_sd;
  assign deselect = cs_s || oe_s;

  state_e               state_q;
  logic                 bus_req_q, bus_write_q, padoe_q, overrun_q;
  logic [N_SRAM_A-1:0]  bus_addr_q;
  logic [N_SRAM_DQ-1:0] bus_wdata_q, padout_q;
  logic [1:0]           bus_be_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= 2'b00;
      padout_q    <= '0;
      padoe_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_edge && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (wr_edge) begin
            // a write with no lanes enabled is silently absorbed
            if (wr_be != 2'b00) begin
              state_q     <= ST_WR_REQ;
              bus_req_q   <= 1'b1;
              bus_write_q <= 1'b1;
              bus_addr_q  <= a_sd;
              bus_wdata_q <= dq_sd;
              bus_be_q    <= wr_be;
            end
          end else if (!cs_s && !oe_s && we_s) begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_WR_REQ: begin
          if (bus_ready) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (deselect) begin
            state_q <= ST_IDLE;
            padoe_q <= 1'b0;
          end else if (a_s == a_sd) begin
            state_q     <= ST_RD_REQ;
            bus_req_q   <= 1'b1;
            bus_write_q <= 1'b0;
            bus_addr_q  <= a_s;
            bus_be_q    <= 2'b11;
          end
        end
        ST_RD_REQ: begin
          // deselect is ignored here so the request is never withdrawn
          if (bus_ready) begin
            state_q   <= ST_RD_DRIVE;
            bus_req_q <= 1'b0;
            padout_q  <= bus_rdata;
            padoe_q   <= 1'b1;
          end
        end
        ST_RD_DRIVE: begin
          if (deselect) begin
            state_q <= ST_IDLE;
            padoe_q <= 1'b0;
          end else if (a_s != a_sd) begin
            state_q <= ST_RD_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req        = bus_req_q;
  assign bus_write      = bus_write_q;
  assign bus_addr       = bus_addr_q;
  assign bus_wdata      = bus_wdata_q;
  assign bus_byte_en    = bus_be_q;
  assign padout_sram_dq = padout_q;
  assign padoe_sram_dq  = {N_SRAM_DQ{padoe_q}};
  assign overrun        = overrun_q;
endmodule
